// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS-16 control unit: states, opcodes,
// ALU operation codes, mux selects and the datapath control word.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_EXC       = 4'd12
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_LW    = 4'b1011;
  localparam logic [3:0] OP_SW    = 4'b1111;
  localparam logic [3:0] OP_BEQ   = 4'b1000;
  localparam logic [3:0] OP_J     = 4'b0010;

  // bit 2 inverts B and feeds carry-in; bits [1:0] pick the result
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_TWO    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCS_ALU     = 2'b00;
  localparam logic [1:0] PCS_ALU_OUT = 2'b01;
  localparam logic [1:0] PCS_JUMP    = 2'b10;
  localparam logic [1:0] PCS_EXC     = 2'b11;

  localparam logic [15:0] EXC_VECTOR = 16'h0010;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       epc_write;
  } ctrl_t;

  function automatic logic funct_legal(input logic [3:0] f);
    return (f == ALU_ADD) || (f == ALU_SUB) || (f == ALU_AND) ||
           (f == ALU_OR)  || (f == ALU_SLT);
  endfunction

  function automatic logic funct_can_overflow(input logic [3:0] f);
    return (f == ALU_ADD) || (f == ALU_SUB);
  endfunction

endpackage

// File: rtl/mc_decode.sv
// State-to-control-word decode for mc_control; only the MEM_READY and ZERO
// gated strobes look at same-cycle inputs. EXC word exists only with OVF_TRAP_EN.
module mc_decode
  import mc_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  input  logic       zero,
  input  logic [3:0] funct,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_TWO;
        ctrl.alu_op    = ALU_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_en     = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = mem_ready;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = funct;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_ADDI_WB: ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_source = PCS_ALU_OUT;
        ctrl.pc_en     = zero;
      end
      S_JUMP: begin
        ctrl.pc_source = PCS_JUMP;
        ctrl.pc_en     = 1'b1;
      end
`ifdef OVF_TRAP_EN
      S_EXC: begin
        ctrl.epc_write = 1'b1;
        ctrl.pc_source = PCS_EXC;
        ctrl.pc_en     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle control FSM for the 16-bit MIPS datapath: state register,
// next-state logic and reset gating of strobes. OVF_TRAP_EN enables the overflow trap.
//
// state     | meaning
// FETCH     | read instruction, PC += 2 on ready
// DECODE    | branch target into ALUOut, dispatch on opcode
// MEM_ADDR  | effective address A + imm
// MEM_RD    | load access, wait for ready
// MEM_WB    | load data into register file
// MEM_WR    | store access, wait for ready
// R_EXEC    | R-type ALU operation
// R_WB      | R-type result write-back
// BRANCH    | compare A - B, take on ZERO
// JUMP      | PC <= jump target
// ADDI_EXEC | A + imm
// ADDI_WB   | ADDI result write-back
// EXC       | overflow trap, EPC and vector 0x0010
module mc_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic [3:0] funct,
  input  logic       zero,
  input  logic       v,
  input  logic       mem_ready,
  output logic [3:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       epc_write,
  output logic       illegal,
  output logic [3:0] state
);

  state_t state_q, state_next;
  logic   illegal_c;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    illegal_c  = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEM_ADDR;
          OP_RTYPE:     state_next = S_R_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_ADDI:      state_next = S_ADDI_EXEC;
          default: begin
            state_next = S_FETCH;
            illegal_c  = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_next = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) state_next = S_FETCH;
      S_R_EXEC: begin
        if (!funct_legal(funct)) begin
          state_next = S_FETCH;
          illegal_c  = 1'b1;
        end
`ifdef OVF_TRAP_EN
        else if (funct_can_overflow(funct) && v) state_next = S_EXC;
`endif
        else state_next = S_R_WB;
      end
      S_ADDI_EXEC: state_next = S_ADDI_WB;
      default:     state_next = S_FETCH;
    endcase
  end

`ifndef OVF_TRAP_EN
  logic unused_v;
  assign unused_v = v;
`endif

  mc_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .zero      (zero),
    .funct     (funct),
    .ctrl      (ctrl)
  );

  // reset holds the state at FETCH, whose word would otherwise read memory
  assign mem_read   = ctrl.mem_read  & rst_n;
  assign mem_write  = ctrl.mem_write & rst_n;
  assign ir_write   = ctrl.ir_write  & rst_n;
  assign pc_en      = ctrl.pc_en     & rst_n;
  assign reg_write  = ctrl.reg_write & rst_n;
  assign epc_write  = ctrl.epc_write & rst_n;
  assign illegal    = illegal_c      & rst_n;
  assign alu_op     = ctrl.alu_op;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign pc_source  = ctrl.pc_source;
  assign iord       = ctrl.iord;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign state      = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed scenarios plus randomized
// instructions checked against an instruction-level model (state trace, strobe counts).
module tb_mc_control;

`ifdef OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode, funct;
  logic       zero, v, mem_ready;
  logic [3:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, epc_write, illegal;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mc_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .v(v), .mem_ready(mem_ready), .alu_op(alu_op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_source(pc_source), .pc_en(pc_en), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .epc_write(epc_write), .illegal(illegal), .state(state)
  );

  localparam logic [3:0] LEGAL_FN [5] = '{4'b0000, 4'b0100, 4'b0001, 4'b0010, 4'b0111};

  function automatic bit fn_is_legal(input logic [3:0] f);
    foreach (LEGAL_FN[i]) if (LEGAL_FN[i] == f) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] illegal_opcode();
    logic [3:0] o;
    do o = 4'($urandom);
    while (o inside {4'b0000, 4'b0100, 4'b1011, 4'b1111, 4'b1000, 4'b0010});
    return o;
  endfunction

  // kind: 0 R-type, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 J, 6 illegal opcode
  task automatic run_instr(input int kind, input logic [3:0] fn, input int wf,
                           input int wm, input logic z, input logic vx);
    logic [3:0] op;
    logic [3:0] seq[$];
    int         rdy[$];
    bit         ill_f, trap, wb_r;
    int c_irw = 0, c_pce = 0, c_rw = 0, c_mw = 0, c_m2r = 0, c_rd = 0;
    int c_epc = 0, c_ill = 0, c_mr = 0, c_exc = 0;
    int e_pce, e_mr;
    case (kind)
      0: op = 4'b0000;
      1: op = 4'b0100;
      2: op = 4'b1011;
      3: op = 4'b1111;
      4: op = 4'b1000;
      5: op = 4'b0010;
      default: op = illegal_opcode();
    endcase
    ill_f = (kind == 0) && !fn_is_legal(fn);
    trap  = TRAP_EN && (kind == 0) && !ill_f && (fn == 4'b0000 || fn == 4'b0100) && vx;
    wb_r  = (kind == 0) && !ill_f && !trap;

    for (int i = 0; i <= wf; i++) begin seq.push_back(4'd0); rdy.push_back(i == wf ? 1 : 0); end
    seq.push_back(4'd1); rdy.push_back(2);
    case (kind)
      0: begin
        seq.push_back(4'd6); rdy.push_back(2);
        if (trap) begin seq.push_back(4'd12); rdy.push_back(2); end
        else if (!ill_f) begin seq.push_back(4'd7); rdy.push_back(2); end
      end
      1: begin seq.push_back(4'd10); rdy.push_back(2); seq.push_back(4'd11); rdy.push_back(2); end
      2: begin
        seq.push_back(4'd2); rdy.push_back(2);
        for (int i = 0; i <= wm; i++) begin seq.push_back(4'd3); rdy.push_back(i == wm ? 1 : 0); end
        seq.push_back(4'd4); rdy.push_back(2);
      end
      3: begin
        seq.push_back(4'd2); rdy.push_back(2);
        for (int i = 0; i <= wm; i++) begin seq.push_back(4'd5); rdy.push_back(i == wm ? 1 : 0); end
      end
      4: begin seq.push_back(4'd8); rdy.push_back(2); end
      5: begin seq.push_back(4'd9); rdy.push_back(2); end
      default: ;
    endcase

    foreach (seq[k]) begin
      @(negedge clk);
      opcode    = (seq[k] == 4'd0) ? 4'($urandom) : op;
      funct     = (seq[k] == 4'd0) ? 4'($urandom) : fn;
      mem_ready = (rdy[k] == 2) ? 1'($urandom) : rdy[k][0];
      zero      = (seq[k] == 4'd8) ? z  : 1'($urandom);
      v         = (seq[k] == 4'd6) ? vx : 1'($urandom);
      #1;
      total++;
      if (state !== seq[k]) begin
        bad++;
        $display("FAIL state kind=%0d cyc=%0d: got %0d want %0d", kind, k, state, seq[k]);
      end
      c_irw += int'(ir_write);  c_pce += int'(pc_en);     c_rw  += int'(reg_write);
      c_mw  += int'(mem_write); c_m2r += int'(mem_to_reg); c_rd  += int'(reg_dst);
      c_epc += int'(epc_write); c_ill += int'(illegal);   c_mr  += int'(mem_read);
      c_exc += int'(pc_source == 2'b11);
      if (seq[k] == 4'd0) begin
        total++;
        if (alu_op !== 4'b0000 || alu_src_b !== 2'b01 || alu_src_a !== 1'b0 || iord !== 1'b0) begin
          bad++;
          $display("FAIL fetch_word: got op=%b srcb=%b srca=%b iord=%b want 0000 01 0 0",
                   alu_op, alu_src_b, alu_src_a, iord);
        end
      end
      if (seq[k] == 4'd6 && !ill_f) begin
        total++;
        if (alu_op !== fn) begin
          bad++;
          $display("FAIL r_exec_alu_op: got %b want %b", alu_op, fn);
        end
      end
      if (seq[k] == 4'd8) begin
        total++;
        if (alu_op !== 4'b0100 || pc_source !== 2'b01 || pc_en !== z) begin
          bad++;
          $display("FAIL branch_word: got op=%b pcs=%b pc_en=%b want 0100 01 %b",
                   alu_op, pc_source, pc_en, z);
        end
      end
      if (seq[k] == 4'd9) begin
        total++;
        if (pc_source !== 2'b10 || pc_en !== 1'b1) begin
          bad++;
          $display("FAIL jump_word: got pcs=%b pc_en=%b want 10 1", pc_source, pc_en);
        end
      end
    end

    e_pce = 1 + ((kind == 5) ? 1 : 0) + ((kind == 4 && z) ? 1 : 0) + (trap ? 1 : 0);
    e_mr  = (wf + 1) + ((kind == 2) ? wm + 1 : 0);
    total++;
    if (c_irw !== 1 || c_pce !== e_pce || c_mr !== e_mr) begin
      bad++;
      $display("FAIL fetch_counts kind=%0d: got irw=%0d pce=%0d mr=%0d want 1 %0d %0d",
               kind, c_irw, c_pce, c_mr, e_pce, e_mr);
    end
    total++;
    if (c_rw !== int'(kind == 1 || kind == 2 || wb_r) || c_rd !== int'(wb_r) ||
        c_m2r !== int'(kind == 2) || c_mw !== int'(kind == 3)) begin
      bad++;
      $display("FAIL write_counts kind=%0d fn=%b: got rw=%0d rd=%0d m2r=%0d mw=%0d",
               kind, fn, c_rw, c_rd, c_m2r, c_mw);
    end
    total++;
    if (c_ill !== int'(kind == 6 || ill_f) || c_epc !== int'(trap) || c_exc !== int'(trap)) begin
      bad++;
      $display("FAIL exc_counts kind=%0d fn=%b v=%b: got ill=%0d epc=%0d pcs11=%0d",
               kind, fn, vx, c_ill, c_epc, c_exc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 4'b0010; funct = 4'd0; zero = 1'b1; v = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (state !== 4'd0 || mem_read !== 1'b0 || ir_write !== 1'b0 || pc_en !== 1'b0 ||
        illegal !== 1'b0 || mem_write !== 1'b0 || reg_write !== 1'b0 || epc_write !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got st=%0d mr=%b irw=%b pce=%b ill=%b want 0 and all 0",
               state, mem_read, ir_write, pc_en, illegal);
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    total++;
    if (state !== 4'd1) begin bad++; $display("FAIL first_fetch: got %0d want 1", state); end
    mem_ready = 1'b0;
    @(negedge clk); #1;
    total++;
    if (state !== 4'd9 || pc_en !== 1'b1) begin
      bad++; $display("FAIL reset_jump: got st=%0d pce=%b want 9 1", state, pc_en);
    end
    @(negedge clk); #1;
    total++;
    if (state !== 4'd0) begin bad++; $display("FAIL reset_jump_ret: got %0d want 0", state); end
  endtask

  task automatic test_rtype_add();
    run_instr(0, 4'b0000, 0, 0, 1'b0, 1'b0);
    run_instr(0, 4'b0111, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_lw_wait();
    int cyc = 0, irw = 0, pce = 0, fw = 0, rw = 0;
    bit done = 0;
    opcode = 4'b1011; funct = 4'd0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (state == 4'd0) begin mem_ready = (fw == 3); fw++; end
      else if (state == 4'd3) begin mem_ready = (rw == 3); rw++; end
      else mem_ready = 1'($urandom);
      #1;
      cyc++;
      irw += int'(ir_write);
      pce += int'(pc_en);
      if (state == 4'd4) done = 1;
    end
    total++;
    if (!done || cyc != 11) begin
      bad++; $display("FAIL lw_cycles: got %0d (done=%0d) want 11", cyc, done);
    end
    total++;
    if (irw != 1 || pce != 1) begin
      bad++; $display("FAIL lw_pulses: got irw=%0d pce=%0d want 1 1", irw, pce);
    end
  endtask

  task automatic test_beq();
    run_instr(4, 4'd0, 1, 0, 1'b1, 1'b0);
    run_instr(4, 4'd0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_illegal();
    int kind6_save;
    kind6_save = 6;
    run_instr(kind6_save, 4'd0, 0, 0, 1'b0, 1'b0);
    run_instr(0, 4'b1001, 2, 0, 1'b0, 1'b1);
  endtask

  task automatic test_ovf();
    run_instr(0, 4'b0100, 0, 0, 1'b0, 1'b1);
    run_instr(0, 4'b0000, 1, 0, 1'b1, 1'b1);
    run_instr(0, 4'b0001, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_write();
    logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      opcode = 4'b1111; funct = 4'd0;
      mem_ready = (k == 0);
      #1;
      total++;
      if (state !== exp_st[k] || mem_write !== 1'b0) begin
        bad++; $display("FAIL sw_lead cyc=%0d: got st=%0d mw=%b want %0d 0", k, state, mem_write, exp_st[k]);
      end
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    total++;
    if (state !== 4'd5 || mem_write !== 1'b1) begin
      bad++; $display("FAIL sw_ready: got st=%0d mw=%b want 5 1", state, mem_write);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (state !== 4'd0 || mem_write !== 1'b0 || mem_read !== 1'b0) begin
      bad++; $display("FAIL reset_mid_write: got st=%0d mw=%b mr=%b want 0 0 0", state, mem_write, mem_read);
    end
    mem_ready = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int k;
      logic [3:0] fn;
      k = $urandom_range(0, 7);
      if (k == 7) begin
        do fn = 4'($urandom); while (fn_is_legal(fn));
        k = 0;
      end else fn = LEGAL_FN[$urandom_range(0, 4)];
      run_instr(k, fn, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_rtype_add();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_ovf();
    test_reset_mid_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
